// File: rtl/dense_layer_engine.sv
// dense_layer_engine
//   Fully-connected layer sequencer and datapath. A single start computes every
//   output neuron j as act(sum_i x[i] * W[j][i]) and writes it to the answer SRAM.
//   The inputs x[i] come from the input SRAM and the weights W[j][i] from the
//   weight SRAM. Both SRAMs have a 1-cycle read latency.
//   Each product is full width, and the sum is kept in a wide accumulator. That
//   sum is shifted down by FRAC_W and saturated to DATA_W.
//   One of three activations is then applied: none, ReLU, or an external
//   sigmoid unit with a fixed latency.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      1-cycle job request, only honoured while idle
//   act_mode   0 none, 1 ReLU, 2 sigmoid, 3 none; latched when start is accepted
//   busy       high from the cycle after start is accepted until the done cycle
//   done       1-cycle pulse after the final answer write
//   in_addr    input SRAM read address (i)
//   in_rdata   input SRAM read data, valid 1 cycle after in_addr
//   w_addr     weight SRAM read address (j*N_IN + i)
//   w_rdata    weight SRAM read data, valid 1 cycle after w_addr
//   sig_in     saturated pre-activation presented to the sigmoid unit
//   sig_out    sigmoid result, valid SIG_LAT cycles after sig_in
//   out_we     answer SRAM write enable (1-cycle pulse per neuron)
//   out_addr   answer SRAM address (neuron index j)
//   out_wdata  activated result
//
// Per-neuron schedule, where P is the period of one neuron:
//   MAC       N_IN cycles
//   DRAIN     1 cycle
//   SAT       1 cycle
//   ACT_WAIT  SIG_LAT cycles, sigmoid only
//   WRITE     1 cycle
//   P = N_IN + 3, plus SIG_LAT when the sigmoid is used.
module dense_layer_engine #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FRAC_W  = 8,
  parameter int unsigned N_IN    = 10,
  parameter int unsigned N_OUT   = 10,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned SIG_LAT = 1,
  localparam int unsigned IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int unsigned W_AW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int unsigned OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        act_mode,
  output logic              busy,
  output logic              done,
  output logic [IN_AW-1:0]  in_addr,
  input  logic [DATA_W-1:0] in_rdata,
  output logic [W_AW-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic [DATA_W-1:0] sig_in,
  input  logic [DATA_W-1:0] sig_out,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata
);

  localparam int unsigned WAIT_W = (SIG_LAT > 1) ? $clog2(SIG_LAT) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;

  // Saturation bounds, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  localparam logic [1:0] ModeRelu    = 2'd1;
  localparam logic [1:0] ModeSigmoid = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StDrain,
    StSat,
    StActWait,
    StWrite,
    StDone
  } state_e;

  state_e                   state_q;
  logic [OUT_AW-1:0]        j_q;
  logic [IN_AW-1:0]         in_addr_q;
  logic [W_AW-1:0]          w_addr_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [1:0]               mode_q;
  logic [WAIT_W-1:0]        wait_q;
  logic [DATA_W-1:0]        sat_q;
  logic [DATA_W-1:0]        out_wdata_q;
  logic [OUT_AW-1:0]        out_addr_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     out_we_q;

  // Datapath helpers
  logic [PROD_W-1:0]        x_ext;
  logic [PROD_W-1:0]        w_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_shr;
  logic [DATA_W-1:0]        sat_val;
  logic [DATA_W-1:0]        relu_val;

  always_comb begin
    x_ext    = {{DATA_W{in_rdata[DATA_W-1]}}, in_rdata};
    w_ext    = {{DATA_W{w_rdata[DATA_W-1]}}, w_rdata};
    // The low PROD_W bits of the product of two sign-extended operands are
    // exactly the signed product.
    prod     = x_ext * w_ext;
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    acc_sum  = acc_q + prod_ext;
    acc_shr  = acc_sum >>> FRAC_W;

    if (acc_shr > SAT_MAX) begin
      sat_val = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (acc_shr < SAT_MIN) begin
      sat_val = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      sat_val = acc_shr[DATA_W-1:0];
    end

    relu_val = sat_q[DATA_W-1] ? '0 : sat_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      j_q         <= '0;
      in_addr_q   <= '0;
      w_addr_q    <= '0;
      acc_q       <= '0;
      mode_q      <= '0;
      wait_q      <= '0;
      sat_q       <= '0;
      out_wdata_q <= '0;
      out_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_we_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_q    <= act_mode;
            j_q       <= '0;
            acc_q     <= '0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
            busy_q    <= 1'b1;
            state_q   <= StMac;
          end
        end

        StMac: begin
          // Read data lags the address by one cycle. At i == 0 the SRAM data
          // still belongs to the previous neuron, so it is not accumulated.
          if (in_addr_q != '0) begin
            acc_q <= acc_sum;
          end
          if (in_addr_q == IN_AW'(N_IN - 1)) begin
            state_q <= StDrain;
          end else begin
            in_addr_q <= in_addr_q + IN_AW'(1);
            w_addr_q  <= w_addr_q + W_AW'(1);
          end
        end

        StDrain: begin
          // Fold in the last product and saturate in the same step.
          // The sigmoid unit then sees sig_in from the SAT cycle onward.
          acc_q   <= acc_sum;
          sat_q   <= sat_val;
          state_q <= StSat;
        end

        StSat: begin
          if (mode_q == ModeSigmoid) begin
            wait_q  <= WAIT_W'(SIG_LAT - 1);
            state_q <= StActWait;
          end else begin
            out_we_q    <= 1'b1;
            out_addr_q  <= j_q;
            out_wdata_q <= (mode_q == ModeRelu) ? relu_val : sat_q;
            state_q     <= StWrite;
          end
        end

        StActWait: begin
          if (wait_q == '0) begin
            out_we_q    <= 1'b1;
            out_addr_q  <= j_q;
            out_wdata_q <= sig_out;
            state_q     <= StWrite;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end

        StWrite: begin
          out_we_q <= 1'b0;
          acc_q    <= '0;
          if (j_q == OUT_AW'(N_OUT - 1)) begin
            j_q     <= '0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            // Weight addresses run contiguously from one neuron row to the next.
            j_q       <= j_q + OUT_AW'(1);
            in_addr_q <= '0;
            w_addr_q  <= w_addr_q + W_AW'(1);
            state_q   <= StMac;
          end
        end

        StDone: begin
          // A start arriving in this cycle is dropped. It is only seen again
          // once the FSM is back in IDLE.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_addr   = in_addr_q;
  assign w_addr    = w_addr_q;
  assign sig_in    = sat_q;
  assign out_we    = out_we_q;
  assign out_addr  = out_addr_q;
  assign out_wdata = out_wdata_q;

endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed bench for dense_layer_engine.
// Environment models:
//   input and weight SRAMs with a 1-cycle read latency;
//   a sigmoid stub that returns sig_in + 1 through three register stages.
// Cycle numbering: start is sampled at edge 0, and cycle c is the interval
// that follows edge c-1.
module tb_dense_layer_engine;

  localparam int N_IN    = 10;
  localparam int N_OUT   = 10;
  localparam int SIG_LAT = 3;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        start    = 1'b0;
  logic [1:0]  act_mode = 2'd0;
  logic        busy;
  logic        done;
  logic [3:0]  in_addr;
  logic [15:0] in_rdata;
  logic [6:0]  w_addr;
  logic [15:0] w_rdata;
  logic [15:0] sig_in;
  logic [15:0] sig_out;
  logic        out_we;
  logic [3:0]  out_addr;
  logic [15:0] out_wdata;

  logic [15:0] xmem [16];
  logic [15:0] wmem [128];
  logic [15:0] expv [N_OUT];
  logic [15:0] s1, s2, s3;

  int compared   = 0;
  int mismatched = 0;

  dense_layer_engine #(
    .DATA_W (16),
    .FRAC_W (8),
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .ACC_W  (40),
    .SIG_LAT(SIG_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .act_mode (act_mode),
    .busy     (busy),
    .done     (done),
    .in_addr  (in_addr),
    .in_rdata (in_rdata),
    .w_addr   (w_addr),
    .w_rdata  (w_rdata),
    .sig_in   (sig_in),
    .sig_out  (sig_out),
    .out_we   (out_we),
    .out_addr (out_addr),
    .out_wdata(out_wdata)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    in_rdata <= xmem[in_addr];
    w_rdata  <= wmem[w_addr];
    s1       <= sig_in + 16'd1;
    s2       <= s1;
    s3       <= s2;
  end
  assign sig_out = s3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] x, input logic [15:0] w_even,
                      input logic [15:0] w_odd, input logic [15:0] e_even,
                      input logic [15:0] e_odd);
    for (int k = 0; k < 16; k++) xmem[k] = x;
    for (int k = 0; k < 128; k++) wmem[k] = ((k / N_IN) % 2 == 0) ? w_even : w_odd;
    for (int k = 0; k < N_OUT; k++) expv[k] = (k % 2 == 0) ? e_even : e_odd;
  endtask

  // One job. Pulses start, then checks every cycle up to the done cycle.
  //   restart_cyc: if nonzero, start is pulsed again in that cycle with a
  //                different act_mode.
  //   abort_cyc:   if nonzero, reset is pulled low in that cycle.
  task automatic run_job(input logic [1:0] m, input int p, input int restart_cyc,
                         input int abort_cyc);
    int last;
    bit aborted;
    last    = N_OUT * p + 1;
    aborted = 1'b0;
    start    = 1'b1;
    act_mode = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      start = (c == restart_cyc);
      if (c == restart_cyc) act_mode = (m == 2'd1) ? 2'd0 : 2'd1;
      if (c == abort_cyc) begin
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_we", 32'(out_we), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_w_addr", 32'(w_addr), 32'd0);
        chk("abort_sig_in", 32'(sig_in), 32'd0);
        chk("abort_out_wdata", 32'(out_wdata), 32'd0);
        aborted = 1'b1;
        break;
      end
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), 32'(c == last));
      chk("out_we", 32'(out_we), 32'((c % p == 0) && (c < last)));
      if ((c % p == 0) && (c < last)) begin
        chk("out_addr", 32'(out_addr), 32'(c / p - 1));
        chk("out_wdata", 32'(out_wdata), 32'(expv[c / p - 1]));
      end
      if ((c % p >= 1) && (c % p <= N_IN) && (c < last)) begin
        chk("in_addr", 32'(in_addr), 32'(c % p - 1));
        chk("w_addr", 32'(w_addr), 32'((c / p) * N_IN + c % p - 1));
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (!aborted) begin
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("done_pulse_end", 32'(done), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    fill(16'h0100, 16'h0080, 16'h0080, 16'h0500, 16'h0500);
    #12;
    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_we", 32'(out_we), 32'd0);
    chk("rst_in_addr", 32'(in_addr), 32'd0);
    chk("rst_w_addr", 32'(w_addr), 32'd0);
    chk("rst_sig_in", 32'(sig_in), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_wdata", 32'(out_wdata), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: 1.0 * 0.5 * 10 = 5.0 -> 0x0500, mode 0
    run_job(2'd0, 13, 0, 0);
    chk("sig_in_hold", 32'(sig_in), 32'h0500);

    // 2a: positive saturation
    fill(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_job(2'd0, 13, 0, 0);

    // 2b: negative saturation, mode 3 passes through; start in the done cycle ignored
    fill(16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    run_job(2'd3, 13, 131, 0);
    @(posedge clk);
    #1;
    chk("start_at_done_ignored", 32'(busy), 32'd0);

    // 3: ReLU, +0.5 rows on even j and -0.5 rows on odd j
    fill(16'h0100, 16'h0080, 16'hFF80, 16'h0500, 16'h0000);
    run_job(2'd1, 13, 0, 0);

    // 4: sigmoid stub (sig_in + 1, 3-cycle latency), P = 16
    fill(16'h0100, 16'h0080, 16'h0080, 16'h0501, 16'h0501);
    run_job(2'd2, 16, 0, 0);

    // 5: second start in cycle 40 with another mode has no effect
    fill(16'h0100, 16'h0080, 16'hFF80, 16'h0500, 16'h0000);
    run_job(2'd1, 13, 40, 0);

    // 6: reset in cycle 45 (neuron 3 MAC), then a clean full job
    fill(16'h0100, 16'h0080, 16'h0080, 16'h0500, 16'h0500);
    run_job(2'd0, 13, 0, 45);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_abort_busy", 32'(busy), 32'd0);
    chk("post_abort_out_we", 32'(out_we), 32'd0);
    run_job(2'd0, 13, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
